// File: rtl/mux_scan_ctrl.sv
// Parallel-to-serial sequencer for an external 8-to-1 mux. It walks mux_select 0..7 and samples
// the mux output at the end of each slot. The resulting serial stream is emitted LSB first.
module mux_scan_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SEL_W       = 3,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             abort,
  output logic             mux_enable,
  output logic [SEL_W-1:0] mux_select,
  output logic [WIDTH-1:0] mux_data,
  input  logic             mux_bit,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             done
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [SEL_W-1:0] BitLast  = SEL_W'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e             state_q, state_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [SEL_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               en_q, en_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               bit_out_q, bit_out_d;
  logic               bit_valid_q, bit_valid_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      bit_cnt_q   <= '0;
      en_q        <= 1'b0;
      sel_q       <= '0;
      data_q      <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      bit_cnt_q   <= bit_cnt_d;
      en_q        <= en_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    bit_cnt_d   = bit_cnt_q;
    en_d        = en_q;
    sel_d       = sel_q;
    data_d      = data_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      StIdle: begin
        en_d  = 1'b0;
        sel_d = '0;
        // abort has priority over an incoming word
        if (load_valid && !abort) begin
          data_d    = load_data;
          en_d      = 1'b1;
          hold_d    = '0;
          bit_cnt_d = '0;
          state_d   = StScan;
        end
      end
      StScan: begin
        if (abort) begin
          state_d   = StIdle;
          en_d      = 1'b0;
          sel_d     = '0;
          hold_d    = '0;
          bit_cnt_d = '0;
        end else if (hold_q == HoldLast) begin
          bit_out_d   = mux_bit;
          bit_valid_d = 1'b1;
          hold_d      = '0;
          if (bit_cnt_q == BitLast) begin
            state_d   = StDone;
            done_d    = 1'b1;
            en_d      = 1'b0;
            sel_d     = '0;
            bit_cnt_d = '0;
          end else begin
            sel_d     = sel_q + SEL_W'(1);
            bit_cnt_d = bit_cnt_q + SEL_W'(1);
          end
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        en_d    = 1'b0;
        sel_d   = '0;
      end
    endcase
  end

  assign load_ready = (state_q == StIdle);
  assign mux_enable = en_q;
  assign mux_select = sel_q;
  assign mux_data   = data_q;
  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: one instance with HOLD_CYCLES=1 and one with HOLD_CYCLES=3.
// Each instance drives a behavioural 8-to-1 mux whose output is fed back to mux_bit.
module tb_mux_scan_ctrl;

  typedef bit bits8_t [8];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       lv1 = 1'b0, ab1 = 1'b0, lr1, me1, mb1, bo1, bv1, dn1;
  logic [7:0] ld1 = '0, md1;
  logic [2:0] ms1;
  logic       lv3 = 1'b0, ab3 = 1'b0, lr3, me3, mb3, bo3, bv3, dn3;
  logic [7:0] ld3 = '0, md3;
  logic [2:0] ms3;

  assign mb1 = me1 ? md1[ms1] : 1'b0;
  assign mb3 = me3 ? md3[ms3] : 1'b0;

  mux_scan_ctrl #(.WIDTH(8), .SEL_W(3), .HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv1), .load_ready(lr1), .load_data(ld1),
    .abort(ab1), .mux_enable(me1), .mux_select(ms1), .mux_data(md1), .mux_bit(mb1),
    .bit_out(bo1), .bit_valid(bv1), .done(dn1)
  );

  mux_scan_ctrl #(.WIDTH(8), .SEL_W(3), .HOLD_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv3), .load_ready(lr3), .load_data(ld3),
    .abort(ab3), .mux_enable(me3), .mux_select(ms3), .mux_data(md3), .mux_bit(mb3),
    .bit_out(bo3), .bit_valid(bv3), .done(dn3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Presents a word to the HOLD=1 instance; returns at the negedge after the accept edge.
  task automatic load1(input logic [7:0] word, input string tag);
    @(negedge clk);
    lv1 = 1'b1;
    ld1 = word;
    @(negedge clk);
    lv1 = 1'b0;
    check({tag, "_en"}, 32'(me1), 1);
    check({tag, "_sel0"}, 32'(ms1), 0);
    check({tag, "_data"}, 32'(md1), 32'(word));
    check({tag, "_busy"}, 32'(lr1), 0);
  endtask

  // Eight consecutive sample cycles on the HOLD=1 instance.
  task automatic scan1(input bits8_t eb, input string tag);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check({tag, "_bv"}, 32'(bv1), 1);
      check({tag, "_bit"}, 32'(bo1), 32'(eb[k-1]));
      check({tag, "_done"}, 32'(dn1), 32'(k == 8));
      check({tag, "_lr"}, 32'(lr1), 0);
    end
    check({tag, "_en_off"}, 32'(me1), 0);
    check({tag, "_sel_off"}, 32'(ms1), 0);
  endtask

  bits8_t eb_aa = '{0, 1, 0, 1, 0, 1, 0, 1};
  bits8_t eb_f0 = '{0, 0, 0, 0, 1, 1, 1, 1};
  bits8_t eb_01 = '{1, 0, 0, 0, 0, 0, 0, 0};
  bits8_t eb_55 = '{1, 0, 1, 0, 1, 0, 1, 0};

  initial begin
    logic seen;

    // 1. reset
    #12;
    check("rst_lr", 32'(lr1), 1);
    check("rst_en", 32'(me1), 0);
    check("rst_sel", 32'(ms1), 0);
    check("rst_bv", 32'(bv1), 0);
    check("rst_done", 32'(dn1), 0);
    check("rst_lr3", 32'(lr3), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // 2. HOLD=1, 8'b10101010
    load1(8'hAA, "t2");
    scan1(eb_aa, "t2");
    @(negedge clk);
    check("t2_ready_back", 32'(lr1), 1);
    check("t2_done_gone", 32'(dn1), 0);
    check("t2_bv_gone", 32'(bv1), 0);

    // 3. HOLD=3, 8'hF0
    @(negedge clk);
    lv3 = 1'b1;
    ld3 = 8'hF0;
    @(negedge clk);
    lv3 = 1'b0;
    check("t3_en", 32'(me3), 1);
    check("t3_sel0", 32'(ms3), 0);
    for (int k = 1; k <= 8; k++) begin
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        if (j < 2) begin
          check("t3_bv_idle", 32'(bv3), 0);
          check("t3_sel_hold", 32'(ms3), 32'(k - 1));
        end else begin
          check("t3_bv", 32'(bv3), 1);
          check("t3_bit", 32'(bo3), 32'(eb_f0[k-1]));
          check("t3_sel_step", 32'(ms3), (k == 8) ? 0 : 32'(k));
          check("t3_done", 32'(dn3), 32'(k == 8));
        end
      end
    end
    @(negedge clk);
    check("t3_ready_back", 32'(lr3), 1);
    check("t3_done_gone", 32'(dn3), 0);

    // IDLE: abort beats a simultaneous load_valid
    @(negedge clk);
    lv1 = 1'b1;
    ld1 = 8'h3C;
    ab1 = 1'b1;
    @(negedge clk);
    lv1 = 1'b0;
    ab1 = 1'b0;
    check("idle_abort_lr", 32'(lr1), 1);
    check("idle_abort_en", 32'(me1), 0);
    check("idle_abort_data", 32'(md1), 32'h00AA);

    // 4. abort at bit 4 of 8'hFF
    load1(8'hFF, "t4");
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("t4_bv", 32'(bv1), 1);
      check("t4_bit", 32'(bo1), 1);
    end
    ab1 = 1'b1;
    @(negedge clk);
    ab1 = 1'b0;
    check("t4_abort_en", 32'(me1), 0);
    check("t4_abort_sel", 32'(ms1), 0);
    check("t4_abort_bv", 32'(bv1), 0);
    check("t4_abort_done", 32'(dn1), 0);
    check("t4_abort_lr", 32'(lr1), 1);
    check("t4_abort_data", 32'(md1), 32'h00FF);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | dn1 | bv1;
    end
    check("t4_quiet", 32'(seen), 0);
    load1(8'h01, "t4b");
    scan1(eb_01, "t4b");
    @(negedge clk);

    // 5. back-to-back with load_valid held high
    @(negedge clk);
    lv1 = 1'b1;
    ld1 = 8'h55;
    @(negedge clk);
    ld1 = 8'hAA;
    check("t5_en", 32'(me1), 1);
    check("t5_data1", 32'(md1), 32'h0055);
    scan1(eb_55, "t5a");
    check("t5_not_queued", 32'(md1), 32'h0055);
    @(negedge clk);
    check("t5_ready", 32'(lr1), 1);
    check("t5_gap_en", 32'(me1), 0);
    @(negedge clk);
    lv1 = 1'b0;
    check("t5_accept2_lr", 32'(lr1), 0);
    check("t5_accept2_en", 32'(me1), 1);
    check("t5_data2", 32'(md1), 32'h00AA);
    scan1(eb_aa, "t5b");
    @(negedge clk);
    check("t5_ready_end", 32'(lr1), 1);

    // 6. async reset mid-scan on the HOLD=3 instance
    @(negedge clk);
    lv3 = 1'b1;
    ld3 = 8'hF0;
    @(negedge clk);
    lv3 = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_pre_en", 32'(me3), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_en", 32'(me3), 0);
    check("t6_sel", 32'(ms3), 0);
    check("t6_data", 32'(md3), 0);
    check("t6_bv", 32'(bv3), 0);
    check("t6_bit", 32'(bo3), 0);
    check("t6_done", 32'(dn3), 0);
    check("t6_lr", 32'(lr3), 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      seen = seen | bv3 | dn3 | me3;
    end
    check("t6_quiet", 32'(seen), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
